// File: rtl/clkdiv_ctrl.sv
// Run-time toggle clock divider: glitch-free start/stop and ratio changes
// that take effect only at period boundaries.
//
//   state   | meaning
//   S_IDLE  | clk_out held low, counter cleared
//   S_RUN   | dividing, en high
//   S_STOP  | en dropped while high; finishing the high phase
module clkdiv_ctrl #(
  parameter int CW           = 8,
  parameter int DEFAULT_HALF = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_half,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic          clk_out,
  output logic          rise_tick,
  output logic          fall_tick,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] half_q, half_d;
  logic [CW-1:0] pend_q, pend_d;
  logic          pend_flag_q, pend_flag_d;
  logic          clk_out_q, clk_out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          err_q, err_d;
  logic          toggle;
  logic          cfg_xfer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      half_q      <= CW'(DEFAULT_HALF);
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      clk_out_q   <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      half_q      <= half_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      clk_out_q   <= clk_out_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    half_d      = half_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    clk_out_d   = clk_out_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    err_d       = 1'b0;
    toggle      = (state_q != S_IDLE) && (count_q == half_q - CW'(1));
    cfg_xfer    = cfg_valid & ~pend_flag_q;

    unique case (state_q)
      S_IDLE: begin
        count_d   = '0;
        clk_out_d = 1'b0;
        if (en) state_d = S_RUN;
      end
      S_RUN, S_STOP: begin
        if (toggle) begin
          clk_out_d = ~clk_out_q;
          count_d   = '0;
          rise_d    = ~clk_out_q;
          fall_d    = clk_out_q;
        end else begin
          count_d = count_q + CW'(1);
        end
        // Stopping is only allowed once the output is (or is about to be) low.
        if (en)              state_d = S_RUN;
        else if (!clk_out_d) state_d = S_IDLE;
        else                 state_d = S_STOP;
        if (state_d == S_IDLE) count_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (pend_flag_q && (fall_d || (state_q != S_IDLE && state_d == S_IDLE))) begin
      half_d      = pend_q;
      pend_flag_d = 1'b0;
    end

    // A value arriving while the divider is (or is becoming) idle needs no deferral.
    if (cfg_xfer) begin
      if (cfg_half == '0) begin
        err_d = 1'b1;
      end else if (state_q == S_IDLE || state_d == S_IDLE) begin
        half_d = cfg_half;
      end else begin
        pend_d      = cfg_half;
        pend_flag_d = 1'b1;
      end
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    cfg_ready = ~pend_flag_q;
    cfg_err   = err_q;
    clk_out   = clk_out_q;
    rise_tick = rise_q;
    fall_tick = fall_q;
  end

endmodule

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
Run-time controller for the team's toggle-style clock divider. It owns the half-period counter and the divided clock output. It accepts new divide ratios over a valid/ready config port and applies them only at period boundaries, so clk_out never carries a runt pulse. It also starts and stops the divided clock cleanly from a level enable, and sits between the CSR block and the clock consumers.

Parameters:
CW, 8, width of half-period count and config value
DEFAULT_HALF, 4, half-period in clk cycles after reset; gives clk/8, matching the existing fixed divider

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
en  in  1  level run request for divided clock
cfg_valid  in  1  new half-period offered
cfg_half  in  CW  requested half-period in clk cycles; 0 is illegal
cfg_ready  out  1  controller can accept cfg
cfg_err  out  1  one-cycle pulse: offered cfg_half was 0
clk_out  out  1  divided clock, registered
rise_tick  out  1  one-cycle pulse in the cycle clk_out is first 1
fall_tick  out  1  one-cycle pulse in the cycle clk_out is first 0
busy  out  1  state is RUN or STOPPING

Behaviour:
- Reset (async): state=IDLE, count=0, clk_out=0, half_reg=DEFAULT_HALF, pend_flag=0, rise_tick=fall_tick=0, cfg_err=0, busy=0, cfg_ready=1.
- States: IDLE, RUN, STOPPING. busy=1 in RUN and STOPPING.
- IDLE: count=0, clk_out=0. If en=1, go to RUN with count=0.
- RUN/STOPPING counting:
  - count increments by 1 each cycle.
  - When count==half_reg-1: toggle clk_out, count<=0, and assert rise_tick or fall_tick, registered alongside clk_out.
  - Resulting period is 2*half_reg cycles with 50% duty.
- Start latency: en sampled high at edge E0 gives RUN from E0. clk_out rises at edge E0+half_reg; rise_tick is high for the cycle after that edge.
- Stop, en=0 in RUN:
  - If clk_out=0: go straight to IDLE, count<=0. The low phase is truncated; no glitch, since the output is already low.
  - If clk_out=1: go to STOPPING and keep counting. At the falling toggle (fall_tick asserted), go to IDLE.
  - The high phase is never shortened.
- STOPPING with en=1 again: return to RUN with no change to count or clk_out.
- Config handshake:
  - Transfer happens when cfg_valid & cfg_ready.
  - cfg_ready = ~pend_flag.
  - cfg_half==0: value is discarded and cfg_err=1 on the next cycle only. No state changes.
  - In IDLE with no pending value: half_reg<=cfg_half immediately.
  - In RUN/STOPPING: pend_reg<=cfg_half, pend_flag<=1.
  - The pending value is applied at the next falling toggle (clk_out 1->0): half_reg<=pend_reg, pend_flag<=0, count<=0.
  - The pending value is also applied on any transition into IDLE.
  - The cycle being completed always uses the old ratio.
- Simultaneous events:
  - Accept and apply in the same cycle cannot happen, because cfg_ready=0 while a value is pending.
  - en falling on the same cycle as a rising toggle: the toggle occurs, then the block goes to STOPPING.
- half_reg=1: clk_out toggles every cycle (clk/2).
- Maximum half_reg = 2^CW-1. count never exceeds half_reg-1.
- Reset mid-operation: immediate return to reset values, clk_out=0 asynchronously, and any pending config is lost.

Test Plan:
- Default ratio: reset, en=1 held → first rise_tick 4 cycles after en sampled; clk_out period 8 cycles, high 4/low 4, for at least 5 periods.
- Reconfigure in RUN: while high, send cfg_half=2 → cfg_ready drops; current period finishes at 8 cycles; next periods are 4 cycles; cfg_ready returns to 1 at the falling toggle.
- Back-pressure and zero: cfg_half=0 with cfg_valid → cfg_err single pulse, half_reg unchanged. A second cfg offered while one is pending is held off (cfg_ready=0) until applied.
- Stop while high: en=0 one cycle after rise → STOPPING; clk_out stays high 4 cycles total, fall_tick, then IDLE, busy=0. Re-asserting en inside STOPPING → continuous clock with no period disturbance.
- Stop while low: en=0 two cycles after a fall → IDLE next cycle, clk_out remains 0, no rise_tick.
- Async reset mid-high with a pending cfg_half=6 → clk_out=0 immediately, half_reg=4, cfg_ready=1. Restart gives an 8-cycle period.
